// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-stage types: handshake stage states and per-stage payload layouts.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned MEMWB_PAYLOAD_W = 104;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  wb_sel;
    } memwb_payload_t;

    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        case (s)
            PS_ONE:  occ = 2'd1;
            PS_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stage handshake bundle; master drives upstream data and downstream ready.
interface pipe_skid_reg_if #(
    parameter int unsigned DATA_W = 104
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer; every output is a register output.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = MEMWB_PAYLOAD_W
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_skid_reg_if.slave bus
);

    pipe_state_e       r_state;
    pipe_state_e       w_next_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = bus.in_valid && (r_state != PS_FULL);
    assign w_out_fire = (r_state != PS_EMPTY) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PS_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next_state;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_main_nxt   = r_main;
        w_skid_nxt   = r_skid;
        if (bus.flush) begin
            w_next_state = PS_EMPTY;
            w_main_nxt   = '0;
            w_skid_nxt   = '0;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_fire) begin
                        w_next_state = PS_ONE;
                        w_main_nxt   = bus.in_data;
                    end
                end
                PS_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_out_fire) begin
                        // main keeps its value on drain so out_data retains the last payload
                        w_next_state = PS_EMPTY;
                    end else if (w_in_fire) begin
                        w_next_state = PS_FULL;
                        w_skid_nxt   = bus.in_data;
                    end
                end
                PS_FULL: begin
                    if (w_out_fire) begin
                        w_next_state = PS_ONE;
                        w_main_nxt   = r_skid;
                    end
                end
                default: begin
                    w_next_state = PS_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state != PS_FULL);
    assign bus.out_valid = (r_state != PS_EMPTY);
    assign bus.out_data  = r_main;
    assign bus.occupancy = state_occupancy(r_state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg at DATA_W=104 and DATA_W=1 against a queue-based FIFO model.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int unsigned WA = MEMWB_PAYLOAD_W;
    localparam int unsigned WB = 1;
    typedef logic [WA-1:0] pa_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_reg_if #(.DATA_W(WA)) ifa ();
    pipe_skid_reg_if #(.DATA_W(WB)) ifb ();

    pipe_skid_reg #(.DATA_W(WA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    pipe_skid_reg #(.DATA_W(WB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int   n_assert = 0;
    int   n_fail   = 0;
    pa_t  q[2][$];
    pa_t  last_out[2];
    logic pend[2];
    pa_t  pend_d[2];

    task automatic chk(input string tag, input pa_t obs, input pa_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            q[d].delete();
            last_out[d] = '0;
            pend[d]     = 1'b0;
            pend_d[d]   = '0;
        end
    endtask

    // FIFO of at most two entries; out_data shows the head, or the last popped value when empty
    task automatic model_step(input int d, input logic iv, input pa_t id,
                              input logic ordy, input logic fl);
        logic inf, outf;
        inf  = iv && (q[d].size() < 2);
        outf = (q[d].size() > 0) && ordy;
        if (pend[d]) begin
            n_assert++;
            assert (iv === 1'b1 && id === pend_d[d]) else begin
                n_fail++;
                $error("FAIL proto_hold%0d: observed v=%b d=0x%0h expected v=1 d=0x%0h",
                       d, iv, id, pend_d[d]);
            end
        end
        pend[d]   = iv && !inf && !fl;
        pend_d[d] = id;
        if (fl) begin
            q[d].delete();
            last_out[d] = '0;
        end else begin
            if (outf) last_out[d] = q[d].pop_front();
            if (inf) q[d].push_back(id);
        end
    endtask

    task automatic check_dut(input int d, input string pfx, input logic ov, input logic ir,
                             input logic [1:0] occ, input pa_t od);
        pa_t exp_d;
        exp_d = (q[d].size() > 0) ? q[d][0] : last_out[d];
        chk({pfx, "_out_valid"}, WA'(ov), WA'(q[d].size() > 0));
        chk({pfx, "_in_ready"},  WA'(ir), WA'(q[d].size() < 2));
        chk({pfx, "_occupancy"}, WA'(occ), WA'(q[d].size()));
        chk({pfx, "_out_data"},  od, exp_d);
    endtask

    task automatic tick();
        model_step(0, ifa.in_valid, ifa.in_data, ifa.out_ready, ifa.flush);
        model_step(1, ifb.in_valid, WA'(ifb.in_data), ifb.out_ready, ifb.flush);
        @(posedge clk);
        @(negedge clk);
        check_dut(0, "a", ifa.out_valid, ifa.in_ready, ifa.occupancy, ifa.out_data);
        check_dut(1, "b", ifb.out_valid, ifb.in_ready, ifb.occupancy, WA'(ifb.out_data));
    endtask

    task automatic drive_a(input logic iv, input pa_t id, input logic ordy, input logic fl);
        ifa.in_valid  = iv;
        ifa.in_data   = id;
        ifa.out_ready = ordy;
        ifa.flush     = fl;
    endtask

    initial begin
        logic [127:0] rnd;
        drive_a(1'b0, '0, 1'b0, 1'b0);
        ifb.in_valid = 1'b0; ifb.in_data = 1'b0; ifb.out_ready = 1'b1; ifb.flush = 1'b0;
        model_reset();

        // reset then idle
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", WA'(ifa.out_valid), '0);
        chk("rst_out_data",  ifa.out_data, '0);
        chk("rst_occupancy", WA'(ifa.occupancy), '0);
        chk("rst_in_ready",  WA'(ifa.in_ready), WA'(1));
        rst_n = 1'b1;
        tick();

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, WA'(i), 1'b1, 1'b0);
            tick();
            chk("stream_data", ifa.out_data, WA'(i));
            chk("stream_occ", WA'(ifa.occupancy), WA'(1));
        end
        drive_a(1'b0, '0, 1'b1, 1'b0);
        tick();

        // back-pressure: A, B fill; C waits
        drive_a(1'b1, WA'('hA), 1'b0, 1'b0); tick();
        drive_a(1'b1, WA'('hB), 1'b0, 1'b0); tick();
        chk("bp_occ", WA'(ifa.occupancy), WA'(2));
        chk("bp_in_ready", WA'(ifa.in_ready), '0);
        chk("bp_hold_a", ifa.out_data, WA'('hA));
        drive_a(1'b1, WA'('hC), 1'b0, 1'b0); tick(); tick();
        chk("bp_hold_a2", ifa.out_data, WA'('hA));
        chk("bp_occ2", WA'(ifa.occupancy), WA'(2));
        drive_a(1'b1, WA'('hC), 1'b1, 1'b0); tick();
        chk("bp_seq_b", ifa.out_data, WA'('hB));
        tick();
        chk("bp_seq_c", ifa.out_data, WA'('hC));
        drive_a(1'b0, '0, 1'b1, 1'b0); tick();

        // flush while FULL with simultaneous 0xD
        drive_a(1'b1, WA'('h1A), 1'b0, 1'b0); tick();
        drive_a(1'b1, WA'('h1B), 1'b0, 1'b0); tick();
        drive_a(1'b1, WA'('hD), 1'b0, 1'b1);
        chk("flush_in_ready", WA'(ifa.in_ready), '0);
        tick();
        chk("flush_occ", WA'(ifa.occupancy), '0);
        chk("flush_out_valid", WA'(ifa.out_valid), '0);
        chk("flush_out_data", ifa.out_data, '0);
        drive_a(1'b0, '0, 1'b1, 1'b0); tick(); tick();
        chk("flush_no_d", WA'(ifa.out_valid), '0);

        // drain retention
        drive_a(1'b1, WA'('h55), 1'b1, 1'b0); tick();
        drive_a(1'b0, '0, 1'b1, 1'b0); tick();
        chk("retain_valid", WA'(ifa.out_valid), '0);
        chk("retain_data", ifa.out_data, WA'('h55));

        // asynchronous reset while FULL
        drive_a(1'b1, WA'('h71), 1'b0, 1'b0); tick();
        drive_a(1'b1, WA'('h72), 1'b0, 1'b0); tick();
        chk("pre_rst_occ", WA'(ifa.occupancy), WA'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", WA'(ifa.out_valid), '0);
        chk("arst_out_data",  ifa.out_data, '0);
        chk("arst_occupancy", WA'(ifa.occupancy), '0);
        chk("arst_in_ready",  WA'(ifa.in_ready), WA'(1));
        model_reset();
        drive_a(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomised traffic on both widths
        for (int c = 0; c < 10000; c++) begin
            if (!pend[0]) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                ifa.in_valid = 1'($urandom_range(0, 1));
                ifa.in_data  = rnd[WA-1:0];
            end
            if (!pend[1]) begin
                ifb.in_valid = 1'($urandom_range(0, 1));
                ifb.in_data  = 1'($urandom_range(0, 1));
            end
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifb.out_ready = ($urandom_range(0, 2) == 0);
            ifa.flush     = ($urandom_range(0, 255) == 0);
            ifb.flush     = ($urandom_range(0, 255) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
